// File: rtl/ddr3_pkg.sv
// ddr3_pkg: shared controller state codes, loopback checker FSM encoding and test pattern.
package ddr3_pkg;
   localparam int STATE_WRITE_DATA = 8;
   localparam int STATE_READ_DATA  = 11;

   typedef enum logic [2:0] {
      CHK_IDLE,
      CHK_WRITE,
      CHK_READ,
      CHK_DRAIN,
      CHK_DONE
   } chk_state_t;

   function automatic logic [31:0] pattern_word(input logic [31:0] idx, input logic [31:0] seed);
      return idx ^ seed;
   endfunction
endpackage

// File: rtl/ddr3_read_expect_pipe.sv
// ddr3_read_expect_pipe: delays {valid,index,address} of each read beat until its data returns.
module ddr3_read_expect_pipe #(
   parameter int LATENCY = 1,
   parameter int IDX_W   = 8,
   parameter int ADDR_W  = 18
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              push_valid,
   input  logic [IDX_W-1:0]  push_idx,
   input  logic [ADDR_W-1:0] push_addr,
   output logic              out_valid,
   output logic [IDX_W-1:0]  out_idx,
   output logic [ADDR_W-1:0] out_addr
);
   logic [LATENCY-1:0] vld;
   logic [IDX_W-1:0]   idx [LATENCY];
   logic [ADDR_W-1:0]  adr [LATENCY];

   always_ff @(posedge clk or posedge reset) begin
      if (reset || flush) vld <= '0;
      else begin
         vld[0] <= push_valid;
         for (int i = 1; i < LATENCY; i++) vld[i] <= vld[i-1];
      end
   end

   // Payload needs no reset: it is only consumed when its valid bit is set.
   always_ff @(posedge clk) begin
      idx[0] <= push_idx;
      adr[0] <= push_addr;
      for (int i = 1; i < LATENCY; i++) begin
         idx[i] <= idx[i-1];
         adr[i] <= adr[i-1];
      end
   end

   assign out_valid = vld[LATENCY-1];
   assign out_idx   = idx[LATENCY-1];
   assign out_addr  = adr[LATENCY-1];
endmodule

// File: rtl/ddr3_loopback_checker.sv
// ddr3_loopback_checker: writes a seeded pattern through the DDR3 controller, reads it back
// and reports mismatches, first failing address and watchdog timeouts.
module ddr3_loopback_checker
   import ddr3_pkg::*;
#(
   parameter int          ADDRESS_BITWIDTH      = 15,
   parameter int          BANK_ADDRESS_BITWIDTH = 3,
   parameter int          DQ_BITWIDTH           = 8,
   parameter int          NUM_OF_TEST_DATA      = 4,
   parameter int unsigned START_ADDRESS         = 0,
   parameter int unsigned PATTERN_SEED          = 'hA5,
   parameter int          MAIN_STATE_BITWIDTH   = 5,
   parameter int          READ_LATENCY          = 1,
   parameter int          TIMEOUT_CYCLES        = 65535
) (
   input  logic                                              clk,
   input  logic                                              reset,
   input  logic                                              start,
   input  logic [MAIN_STATE_BITWIDTH-1:0]                    main_state,
   input  logic [DQ_BITWIDTH-1:0]                            data_from_ram,
   output logic                                              write_enable,
   output logic                                              read_enable,
   output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
   output logic [DQ_BITWIDTH-1:0]                            data_to_ram,
   output logic                                              busy,
   output logic                                              done,
   output logic                                              error,
   output logic                                              timeout,
   output logic [15:0]                                       error_count,
   output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_error_address
);
   localparam int AW = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
   localparam int CW = $clog2(NUM_OF_TEST_DATA + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   chk_state_t           state;
   logic [CW-1:0]        wr_cnt, rd_cnt, rx_cnt;
   logic [TW-1:0]        wdog;
   logic                 wr_beat, rd_beat, active, abort, rx_valid, rx_bad;
   logic [DQ_BITWIDTH-1:0] rx_idx;
   logic [AW-1:0]        rx_addr;

   function automatic logic [DQ_BITWIDTH-1:0] pat(input logic [31:0] i);
      return DQ_BITWIDTH'(pattern_word(i, PATTERN_SEED));
   endfunction

   assign wr_beat = state == CHK_WRITE && main_state == MAIN_STATE_BITWIDTH'(STATE_WRITE_DATA);
   assign rd_beat = state == CHK_READ && main_state == MAIN_STATE_BITWIDTH'(STATE_READ_DATA);
   assign active  = state == CHK_WRITE || state == CHK_READ || state == CHK_DRAIN;
   assign abort   = active && !(wr_beat || rd_beat || rx_valid) && wdog == TW'(TIMEOUT_CYCLES - 1);
   assign rx_bad  = rx_valid && data_from_ram != pat(32'(rx_idx));

   ddr3_read_expect_pipe #(
      .LATENCY (READ_LATENCY),
      .IDX_W   (DQ_BITWIDTH),
      .ADDR_W  (AW)
   ) u_pipe (
      .clk        (clk),
      .reset      (reset),
      .flush      (abort),
      .push_valid (rd_beat),
      .push_idx   (DQ_BITWIDTH'(rd_cnt)),
      .push_addr  (i_user_data_address),
      .out_valid  (rx_valid),
      .out_idx    (rx_idx),
      .out_addr   (rx_addr)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state               <= CHK_IDLE;
         write_enable        <= 1'b0;
         read_enable         <= 1'b0;
         i_user_data_address <= AW'(START_ADDRESS);
         data_to_ram         <= '0;
         busy                <= 1'b0;
         done                <= 1'b0;
         error               <= 1'b0;
         timeout             <= 1'b0;
         error_count         <= '0;
         first_error_address <= '0;
         wr_cnt              <= '0;
         rd_cnt              <= '0;
         rx_cnt              <= '0;
         wdog                <= '0;
      end else begin
         wdog <= (!active || wr_beat || rd_beat || rx_valid) ? '0 : wdog + 1'b1;
         if (abort) begin
            state        <= CHK_DONE;
            write_enable <= 1'b0;
            read_enable  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b1;
            error        <= 1'b1;
            timeout      <= 1'b1;
         end else begin
            unique case (state)
               CHK_IDLE, CHK_DONE: if (start) begin
                  state               <= CHK_WRITE;
                  write_enable        <= 1'b1;
                  i_user_data_address <= AW'(START_ADDRESS);
                  data_to_ram         <= pat(32'd0);
                  busy                <= 1'b1;
                  done                <= 1'b0;
                  error               <= 1'b0;
                  timeout             <= 1'b0;
                  error_count         <= '0;
                  first_error_address <= '0;
                  wr_cnt              <= '0;
                  rd_cnt              <= '0;
                  rx_cnt              <= '0;
               end
               CHK_WRITE: if (wr_beat) begin
                  wr_cnt <= wr_cnt + 1'b1;
                  if (wr_cnt == CW'(NUM_OF_TEST_DATA - 1)) begin
                     state               <= CHK_READ;
                     write_enable        <= 1'b0;
                     read_enable         <= 1'b1;
                     i_user_data_address <= AW'(START_ADDRESS);
                  end else begin
                     i_user_data_address <= i_user_data_address + 1'b1;
                     data_to_ram         <= pat(32'(wr_cnt) + 32'd1);
                  end
               end
               CHK_READ: if (rd_beat) begin
                  rd_cnt              <= rd_cnt + 1'b1;
                  i_user_data_address <= i_user_data_address + 1'b1;
                  if (rd_cnt == CW'(NUM_OF_TEST_DATA - 1)) begin
                     state       <= CHK_DRAIN;
                     read_enable <= 1'b0;
                  end
               end
               CHK_DRAIN: if (rx_cnt == CW'(NUM_OF_TEST_DATA)) begin
                  state <= CHK_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  error <= error_count != '0;
               end
               default: state <= CHK_IDLE;
            endcase
         end
         // Returned words are compared in READ as well as DRAIN; a zero count marks the first miss.
         if (rx_valid) begin
            rx_cnt <= rx_cnt + 1'b1;
            if (rx_bad) begin
               error_count <= &error_count ? error_count : error_count + 1'b1;
               if (error_count == '0) first_error_address <= rx_addr;
            end
         end
      end
   end
endmodule

// File: tb/tb_ddr3_loopback_checker.sv
// tb_ddr3_loopback_checker: directed loopback runs against a latency-1 and a latency-3 checker.
module tb_ddr3_loopback_checker;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  corrupt = 8'h00;
   logic [4:0]  ms [2];
   logic        st [2];
   logic [7:0]  din [2];
   logic        we [2], re [2], bsy [2], dn [2], er [2], to [2];
   logic [17:0] ad [2], fe [2];
   logic [7:0]  dt [2];
   logic [15:0] ec [2];
   int checks = 0;
   int failures = 0;
   logic [7:0] exp_d [4] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6};

   always #5 clk = ~clk;

   ddr3_loopback_checker #(.READ_LATENCY(1), .TIMEOUT_CYCLES(100)) dut0 (
      .clk(clk), .reset(reset), .start(st[0]), .main_state(ms[0]), .data_from_ram(din[0]),
      .write_enable(we[0]), .read_enable(re[0]), .i_user_data_address(ad[0]), .data_to_ram(dt[0]),
      .busy(bsy[0]), .done(dn[0]), .error(er[0]), .timeout(to[0]), .error_count(ec[0]),
      .first_error_address(fe[0]));

   ddr3_loopback_checker #(.READ_LATENCY(3), .TIMEOUT_CYCLES(100)) dut1 (
      .clk(clk), .reset(reset), .start(st[1]), .main_state(ms[1]), .data_from_ram(din[1]),
      .write_enable(we[1]), .read_enable(re[1]), .i_user_data_address(ad[1]), .data_to_ram(dt[1]),
      .busy(bsy[1]), .done(dn[1]), .error(er[1]), .timeout(to[1]), .error_count(ec[1]),
      .first_error_address(fe[1]));

   // Controller model: stores written words, returns them (optionally corrupted at address 2) after the latency.
   for (genvar g = 0; g < 2; g++) begin : model
      logic [7:0] mem [16];
      logic [7:0] p [3];
      always @(posedge clk) begin
         if (we[g] && ms[g] == 5'd8) mem[ad[g][3:0]] <= dt[g];
         p[0] <= (re[g] && ms[g] == 5'd11) ? mem[ad[g][3:0]] ^ ((ad[g] == 18'd2) ? corrupt : 8'h00) : 8'h00;
         p[1] <= p[0];
         p[2] <= p[1];
      end
      assign din[g] = (g == 0) ? p[0] : p[2];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input int k);
      st[k] = 1'b1;
      tick();
      st[k] = 1'b0;
      chk("start_busy", 32'(bsy[k]), 1);
      chk("start_we", 32'(we[k]), 1);
      chk("start_addr", 32'(ad[k]), 0);
      chk("start_data", 32'(dt[k]), 32'hA5);
      chk("start_done", 32'(dn[k]), 0);
      chk("start_ec", 32'(ec[k]), 0);
      chk("start_err", 32'(er[k]), 0);
   endtask

   task automatic writes(input int k);
      for (int i = 0; i < 4; i++) begin
         if (i == 2) begin
            ms[k] = 5'd0;
            tick();
         end
         ms[k] = 5'd8;
         chk("wr_addr", 32'(ad[k]), 32'(i));
         chk("wr_data", 32'(dt[k]), 32'(exp_d[i]));
         tick();
      end
      ms[k] = 5'd0;
      chk("wr_end_we", 32'(we[k]), 0);
      chk("wr_end_re", 32'(re[k]), 1);
      chk("wr_end_addr", 32'(ad[k]), 0);
   endtask

   task automatic reads(input int k, input int n, input bit gap);
      for (int i = 0; i < n; i++) begin
         if (gap) begin
            ms[k] = 5'd0;
            tick();
         end
         ms[k] = 5'd11;
         tick();
      end
      ms[k] = 5'd0;
   endtask

   task automatic wait_done(input int k);
      for (int n = 0; n < 30 && !dn[k]; n++) tick();
      chk("done", 32'(dn[k]), 1);
      chk("done_busy", 32'(bsy[k]), 0);
      chk("done_re", 32'(re[k]), 0);
   endtask

   initial begin
      ms[0] = 5'd0; ms[1] = 5'd0; st[0] = 1'b0; st[1] = 1'b0;
      repeat (3) tick();
      for (int k = 0; k < 2; k++) begin
         chk("rst_we", 32'(we[k]), 0);
         chk("rst_re", 32'(re[k]), 0);
         chk("rst_addr", 32'(ad[k]), 0);
         chk("rst_busy", 32'(bsy[k]), 0);
         chk("rst_done", 32'(dn[k]), 0);
         chk("rst_ec", 32'(ec[k]), 0);
      end
      reset = 1'b0;
      tick();

      // Clean run, latency 1
      start_run(0);
      writes(0);
      reads(0, 4, 0);
      wait_done(0);
      chk("clean_err", 32'(er[0]), 0);
      chk("clean_ec", 32'(ec[0]), 0);
      chk("clean_fea", 32'(fe[0]), 0);
      chk("clean_to", 32'(to[0]), 0);

      // Word 2 corrupted
      corrupt = 8'h01;
      start_run(0);
      writes(0);
      reads(0, 4, 0);
      wait_done(0);
      chk("bad_err", 32'(er[0]), 1);
      chk("bad_ec", 32'(ec[0]), 1);
      chk("bad_fea", 32'(fe[0]), 2);
      chk("bad_to", 32'(to[0]), 0);
      corrupt = 8'h00;

      // start during READ is ignored; new run clears the previous error count
      start_run(0);
      writes(0);
      reads(0, 2, 0);
      st[0] = 1'b1;
      tick();
      st[0] = 1'b0;
      chk("ign_busy", 32'(bsy[0]), 1);
      chk("ign_re", 32'(re[0]), 1);
      chk("ign_addr", 32'(ad[0]), 2);
      chk("ign_done", 32'(dn[0]), 0);
      reads(0, 2, 0);
      wait_done(0);
      chk("rerun_err", 32'(er[0]), 0);
      chk("rerun_ec", 32'(ec[0]), 0);

      // Watchdog: no read beats for 100 cycles
      start_run(0);
      writes(0);
      repeat (99) tick();
      chk("to_early", 32'(to[0]), 0);
      chk("to_early_done", 32'(dn[0]), 0);
      chk("to_early_re", 32'(re[0]), 1);
      tick();
      chk("to_flag", 32'(to[0]), 1);
      chk("to_done", 32'(dn[0]), 1);
      chk("to_err", 32'(er[0]), 1);
      chk("to_re", 32'(re[0]), 0);
      chk("to_busy", 32'(bsy[0]), 0);

      // Asynchronous reset after two write beats
      start_run(0);
      ms[0] = 5'd8;
      tick();
      tick();
      ms[0] = 5'd0;
      chk("mid_addr", 32'(ad[0]), 2);
      #2 reset = 1'b1;
      #1;
      chk("arst_we", 32'(we[0]), 0);
      chk("arst_addr", 32'(ad[0]), 0);
      chk("arst_data", 32'(dt[0]), 0);
      chk("arst_busy", 32'(bsy[0]), 0);
      chk("arst_err", 32'(er[0]), 0);
      chk("arst_to", 32'(to[0]), 0);
      tick();
      reset = 1'b0;
      tick();
      start_run(0);
      writes(0);
      reads(0, 4, 0);
      wait_done(0);
      chk("post_rst_err", 32'(er[0]), 0);

      // Latency 3 with bursty read beats
      start_run(1);
      writes(1);
      reads(1, 2, 0);
      reads(1, 2, 1);
      wait_done(1);
      chk("l3_err", 32'(er[1]), 0);
      chk("l3_ec", 32'(ec[1]), 0);
      corrupt = 8'h01;
      start_run(1);
      writes(1);
      reads(1, 4, 1);
      wait_done(1);
      chk("l3_bad_err", 32'(er[1]), 1);
      chk("l3_bad_ec", 32'(ec[1]), 1);
      chk("l3_bad_fea", 32'(fe[1]), 2);
      corrupt = 8'h00;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
